// File: rtl/io_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : io_step_sequencer
//  Description : Hardwired control-step sequencer for the RISC datapath.
//                Walks the instruction fetch (T0-T2) and the IN/OUT execute
//                step (T3), driving the datapath control strobes directly.
//                T1 stalls on memory wait states; T3 waits on the port
//                handshake, bounded by WAIT_MAX cycles.
//                Optional retired-instruction counter: define ICOUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_step_sequencer #(
    parameter int               OPC_W    = 5,
    parameter logic [OPC_W-1:0] OPC_IN   = 5'b10110,
    parameter logic [OPC_W-1:0] OPC_OUT  = 5'b10111,
    parameter int               WAIT_MAX = 16,
    parameter int               CNT_W    = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             PCout,
    output logic             IncPC,
    output logic             MARin,
    output logic             ZLowIn,
    output logic             Zlowout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Rin,
    output logic             Rout,
    output logic             InPortout,
    output logic             OutPortin,
    output logic [2:0]       step,
`ifdef ICOUNT_EN
    output logic [CNT_W-1:0] icount,
`endif
    output logic             busy,
    output logic             illegal,
    output logic             timeout
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_T0   = 3'd1;
    localparam logic [2:0] c_ST_T1   = 3'd2;
    localparam logic [2:0] c_ST_T2   = 3'd3;
    localparam logic [2:0] c_ST_T3   = 3'd4;

    // Wait counter must be able to hold WAIT_MAX itself.
    localparam int                  c_WCNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_MAX = c_WCNT_W'(WAIT_MAX);

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_illegal;
    logic                r_timeout;

    logic w_is_in;
    logic w_is_out;
    logic w_legal;
    logic w_hs;
    logic w_wait_done;
    logic w_in_t3;
    logic w_t3_exit;

    // Opcode decode and T3 handshake qualification; a met handshake always
    // takes priority over an expiring wait counter.
    always_comb begin
        w_is_in     = (opcode == OPC_IN);
        w_is_out    = (opcode == OPC_OUT);
        w_legal     = w_is_in | w_is_out;
        w_hs        = (w_is_in & in_valid) | (w_is_out & out_ready);
        w_wait_done = (r_wait_cnt == c_WAIT_MAX);
        w_in_t3     = (r_state == c_ST_T3);
        w_t3_exit   = w_in_t3 & (w_hs | ~w_legal | w_wait_done);
    end

    // Next-state logic; run only matters in IDLE and at the T3 exit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (run) w_next_state = c_ST_T0;
            c_ST_T0:   w_next_state = c_ST_T1;
            c_ST_T1:   if (mem_ready) w_next_state = c_ST_T2;
            c_ST_T2:   w_next_state = c_ST_T3;
            c_ST_T3:   if (w_t3_exit) w_next_state = run ? c_ST_T0 : c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // State, T3 wait counter and sticky error flags.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // T2 is the only predecessor of T3, so clearing here restarts
            // the count on every T3 entry.
            if (r_state == c_ST_T2) begin
                r_wait_cnt <= '0;
            end else if (w_in_t3 && !w_t3_exit) begin
                r_wait_cnt <= r_wait_cnt + c_WCNT_W'(1);
            end
            if (w_in_t3 && !w_legal) begin
                r_illegal <= 1'b1;
            end
            if (w_in_t3 && w_legal && !w_hs && w_wait_done) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef ICOUNT_EN
    logic [CNT_W-1:0] r_icount;

    // Count only instructions that retired through a completed handshake.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_icount <= '0;
        end else if (w_in_t3 && w_hs) begin
            r_icount <= r_icount + CNT_W'(1);
        end
    end

    assign icount = r_icount;
`endif

    // Control strobe decode from the registered state plus live qualifiers.
    always_comb begin
        PCout     = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        ZLowIn    = 1'b0;
        Zlowout   = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Gra       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        InPortout = 1'b0;
        OutPortin = 1'b0;
        case (r_state)
            c_ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            c_ST_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // Loads the incremented PC once, on the cycle T1 completes.
                PCin    = mem_ready;
            end
            c_ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            c_ST_T3: begin
                if (w_is_in && in_valid) begin
                    Gra       = 1'b1;
                    Rin       = 1'b1;
                    InPortout = 1'b1;
                end
                if (w_is_out && out_ready) begin
                    Gra       = 1'b1;
                    Rout      = 1'b1;
                    OutPortin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign step    = r_state;
    assign busy    = (r_state != c_ST_IDLE);
    assign illegal = r_illegal;
    assign timeout = r_timeout;

endmodule
`default_nettype wire
